// File: rtl/pwm_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_mon_pkg
//  Description : Shared types and constants for the PWM duty monitor:
//                per-channel state encoding, counter/duty widths, the
//                duty mid-point and high-time saturation limit, and a
//                helper computing the magnitude of a duty difference.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_mon_pkg;

    // Period counter must be able to reach the largest TIMEOUT in use.
    localparam int CNT_W  = 16;
    // High-time counter saturates at HI_MAX, so 11 bits suffice.
    localparam int HI_W   = 11;
    // Signed duty: high time minus MID, range -1024..+1023.
    localparam int DUTY_W = 12;

    localparam int MID    = 1024;
    localparam int HI_MAX = 2047;

    localparam logic [DUTY_W-1:0] DUTY_MID_C = DUTY_W'(MID);
    localparam logic [DUTY_W-1:0] DUTY_MAX_C = 12'h3FF;   // +1023
    localparam logic [DUTY_W-1:0] DUTY_MIN_C = 12'hC00;   // -1024
    localparam logic [HI_W-1:0]   HI_MAX_C   = HI_W'(HI_MAX);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEAS      = 2'd1,
        STUCK     = 2'd2
    } chan_state_e;

    // |a - b| for two signed duties; one extra bit keeps the full range.
    function automatic logic [DUTY_W:0] duty_abs_diff(
        input logic signed [DUTY_W-1:0] a,
        input logic signed [DUTY_W-1:0] b
    );
        logic signed [DUTY_W:0] d;
        d = {a[DUTY_W-1], a} - {b[DUTY_W-1], b};
        if (d[DUTY_W]) begin
            return -d;
        end
        return d;
    endfunction

endpackage : pwm_mon_pkg
`default_nettype wire

// File: rtl/pwm_chan_meas.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_chan_meas
//  Description : Measures the duty of one PWM1 signal. Each rising edge
//                closes a period and publishes duty = high_time - MID with
//                a one-cycle vld pulse. If no rising edge is seen for
//                TIMEOUT clocks the channel is declared stuck and the duty
//                is forced to the rail matching the current PWM1 level.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                pwm1      - PWM input, already in the clk domain
//                duty      - signed duty of the last completed period
//                vld       - one-cycle pulse when duty updates
//                stuck     - no rising edge for TIMEOUT clocks
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_chan_meas
    import pwm_mon_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pwm1,
    output logic signed [DUTY_W-1:0] duty,
    output logic                     vld,
    output logic                     stuck
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    chan_state_e       state_q,    state_d;
    logic              pwm_prev_q, pwm_prev_d;
    logic [CNT_W-1:0]  per_cnt_q,  per_cnt_d;
    logic [HI_W-1:0]   hi_cnt_q,   hi_cnt_d;
    logic [DUTY_W-1:0] duty_q,     duty_d;
    logic              vld_q,      vld_d;
    logic              stuck_q,    stuck_d;

    logic rise;
    logic timed_out;

    assign rise      = pwm1 & ~pwm_prev_q;
    assign timed_out = (per_cnt_q == TIMEOUT_C);

    always_comb begin
        state_d    = state_q;
        pwm_prev_d = pwm1;
        per_cnt_d  = per_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        duty_d     = duty_q;
        vld_d      = 1'b0;
        stuck_d    = stuck_q;

        case (state_q)
            WAIT_EDGE: begin
                // First edge only starts a period; nothing to publish yet.
                if (rise) begin
                    state_d   = MEAS;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = HI_W'(1);
                end else if (timed_out) begin
                    state_d = STUCK;
                    stuck_d = 1'b1;
                    vld_d   = 1'b1;
                    duty_d  = pwm1 ? DUTY_MAX_C : DUTY_MIN_C;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                end
            end

            MEAS: begin
                if (rise) begin
                    // hi_cnt holds the high cycles of the period just closed;
                    // the edge cycle itself is the first high cycle of the next.
                    duty_d    = {1'b0, hi_cnt_q} - DUTY_MID_C;
                    vld_d     = 1'b1;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = HI_W'(1);
                end else if (timed_out) begin
                    state_d = STUCK;
                    stuck_d = 1'b1;
                    vld_d   = 1'b1;
                    duty_d  = pwm1 ? DUTY_MAX_C : DUTY_MIN_C;
                end else begin
                    per_cnt_d = per_cnt_q + CNT_W'(1);
                    if (pwm1 && (hi_cnt_q != HI_MAX_C)) begin
                        hi_cnt_d = hi_cnt_q + HI_W'(1);
                    end
                end
            end

            STUCK: begin
                // Recovery edge restarts measurement; the partial period
                // before it is meaningless, so no vld here.
                if (rise) begin
                    state_d   = MEAS;
                    stuck_d   = 1'b0;
                    per_cnt_d = CNT_W'(1);
                    hi_cnt_d  = HI_W'(1);
                end
            end

            default: begin
                state_d = WAIT_EDGE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_EDGE;
            pwm_prev_q <= 1'b0;
            per_cnt_q  <= '0;
            hi_cnt_q   <= '0;
            duty_q     <= '0;
            vld_q      <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pwm_prev_q <= pwm_prev_d;
            per_cnt_q  <= per_cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            duty_q     <= duty_d;
            vld_q      <= vld_d;
            stuck_q    <= stuck_d;
        end
    end

    assign duty  = duty_q;
    assign vld   = vld_q;
    assign stuck = stuck_q;

endmodule : pwm_chan_meas
`default_nettype wire

// File: rtl/pwm_duty_mon.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_mon
//  Description : Dual-motor PWM duty monitor. One pwm_chan_meas per motor
//                measures PWM1 duty and detects a stuck channel. This level
//                adds the sticky shoot-through (PWM1 & PWM2) flag and a
//                settled indicator that requires both duties to stay within
//                TOL counts for SETTLE_N consecutive left periods.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                PWM1/2_lft, _rght   - motor PWM pairs (clk domain)
//                clr_err             - clears ovr_lap
//                lft_duty, rght_duty - signed duty (high time - 1024)
//                lft_vld, rght_vld   - duty update pulses
//                stuck               - {lft, rght} no-edge timeout flags
//                ovr_lap             - sticky PWM1/PWM2 overlap flag
//                settled             - duties stable for SETTLE_N periods
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_duty_mon
    import pwm_mon_pkg::*;
#(
    parameter int TOL      = 8,
    parameter int SETTLE_N = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PWM1_lft,
    input  logic                     PWM2_lft,
    input  logic                     PWM1_rght,
    input  logic                     PWM2_rght,
    input  logic                     clr_err,
    output logic signed [DUTY_W-1:0] lft_duty,
    output logic signed [DUTY_W-1:0] rght_duty,
    output logic                     lft_vld,
    output logic                     rght_vld,
    output logic [1:0]               stuck,
    output logic                     ovr_lap,
    output logic                     settled
);

    localparam int                RUN_W     = $clog2(SETTLE_N + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX_C = RUN_W'(SETTLE_N);
    localparam logic [DUTY_W:0]   TOL_C     = (DUTY_W + 1)'(TOL);

    logic lft_stuck;
    logic rght_stuck;

    pwm_chan_meas #(
        .TIMEOUT (TIMEOUT)
    ) u_lft (
        .clk   (clk),
        .rst   (rst),
        .pwm1  (PWM1_lft),
        .duty  (lft_duty),
        .vld   (lft_vld),
        .stuck (lft_stuck)
    );

    pwm_chan_meas #(
        .TIMEOUT (TIMEOUT)
    ) u_rght (
        .clk   (clk),
        .rst   (rst),
        .pwm1  (PWM1_rght),
        .duty  (rght_duty),
        .vld   (rght_vld),
        .stuck (rght_stuck)
    );

    assign stuck = {lft_stuck, rght_stuck};

    // ------------------------------------------------------------------
    // Overlap flag: set has priority over clear.
    // ------------------------------------------------------------------
    logic ovr_lap_q, ovr_lap_d;
    logic ovr_set;

    assign ovr_set = (PWM1_lft & PWM2_lft) | (PWM1_rght & PWM2_rght);

    always_comb begin
        ovr_lap_d = ovr_set | (ovr_lap_q & ~clr_err);
    end

    // ------------------------------------------------------------------
    // Settle tracking, evaluated once per left period. The right duty is
    // sampled at the same instants so both use the same time base.
    // ------------------------------------------------------------------
    logic [RUN_W-1:0]         run_q,       run_d;
    logic                     seeded_q,    seeded_d;
    logic signed [DUTY_W-1:0] hist_lft_q,  hist_lft_d;
    logic signed [DUTY_W-1:0] hist_rght_q, hist_rght_d;

    logic [DUTY_W:0] diff_lft;
    logic [DUTY_W:0] diff_rght;
    logic            both_stable;

    assign diff_lft    = duty_abs_diff(lft_duty,  hist_lft_q);
    assign diff_rght   = duty_abs_diff(rght_duty, hist_rght_q);
    assign both_stable = (diff_lft <= TOL_C) && (diff_rght <= TOL_C);

    always_comb begin
        run_d       = run_q;
        seeded_d    = seeded_q;
        hist_lft_d  = hist_lft_q;
        hist_rght_d = hist_rght_q;

        if (lft_vld) begin
            hist_lft_d  = lft_duty;
            hist_rght_d = rght_duty;
            seeded_d    = 1'b1;
            // Until history is seeded there is nothing to compare against.
            if (seeded_q) begin
                if (both_stable) begin
                    if (run_q != RUN_MAX_C) begin
                        run_d = run_q + RUN_W'(1);
                    end
                end else begin
                    run_d = '0;
                end
            end
        end

        if (|stuck) begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_lap_q   <= 1'b0;
            run_q       <= '0;
            seeded_q    <= 1'b0;
            hist_lft_q  <= '0;
            hist_rght_q <= '0;
        end else begin
            ovr_lap_q   <= ovr_lap_d;
            run_q       <= run_d;
            seeded_q    <= seeded_d;
            hist_lft_q  <= hist_lft_d;
            hist_rght_q <= hist_rght_d;
        end
    end

    assign ovr_lap = ovr_lap_q;
    assign settled = (run_q == RUN_MAX_C);

endmodule : pwm_duty_mon
`default_nettype wire

// File: doc/pwm_duty_mon.md
PWM_DUTY_MON -- requirements
Module: pwm_duty_mon

Interface
REQ-001 The block SHALL have parameter TOL, default 8, giving the maximum per-period duty change (counts) still considered stable.
REQ-002 The block SHALL have parameter SETTLE_N, default 8, giving the consecutive stable periods required to assert settled.
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, giving the clocks without a PWM1 rising edge before the channel is declared stuck.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  system clock; all logic on posedge.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght  in  1 each  motor drive PWM pairs, clk-domain, not synchronized.
REQ-008 Port: clr_err  in  1  clears the sticky ovr_lap flag.
REQ-009 Port: lft_duty, rght_duty  out  12  signed duty, high time minus 1024.
REQ-010 Port: lft_vld, rght_vld  out  1  one-cycle pulse when the corresponding duty updates.
REQ-011 Port: stuck  out  2  {lft,rght}, channel has had no PWM1 edge for TIMEOUT clocks.
REQ-012 Port: ovr_lap  out  1  sticky; PWM1 and PWM2 of the same motor were high together.
REQ-013 Port: settled  out  1  both duties stable for SETTLE_N lft periods.

Function
REQ-014 A rising edge SHALL be PWM1=1 in the current cycle with the registered previous sample =0.
REQ-015 Each channel SHALL implement an FSM with states WAIT_EDGE, MEAS and STUCK.
REQ-016 WAIT_EDGE SHALL go to MEAS on the first rising edge, set per_cnt=1 and hi_cnt=1, and produce no vld.
REQ-017 In MEAS, per_cnt SHALL increment every cycle and hi_cnt SHALL increment on cycles with PWM1=1, saturating at 2047.
REQ-018 On a rising edge in MEAS, duty SHALL be registered as hi_cnt-1024 (12-bit signed, range -1024..+1023).
REQ-019 The vld pulse SHALL assert on the cycle after the edge, coincident with the new duty value, giving a latency of 1 clock.
REQ-020 On a rising edge in MEAS, both counters SHALL restart at 1.
REQ-021 When per_cnt reaches TIMEOUT in WAIT_EDGE or MEAS, the channel SHALL go to STUCK, set its stuck bit and pulse vld once.
REQ-022 On that STUCK entry, duty SHALL be forced to +1023 if PWM1=1 and to -1024 otherwise.
REQ-023 STUCK SHALL go to MEAS on the next rising edge: stuck clears, counters restart at 1, and no vld is produced for the partial period.
REQ-024 If PWM1&PWM2 of either motor are high in a cycle, ovr_lap SHALL set on the next cycle.
REQ-025 ovr_lap SHALL clear only on clr_err or rst; when clr_err coincides with a new overlap, set SHALL win.
REQ-026 On each lft_vld, the block SHALL compare the new lft_duty against the previous lft_duty, and the current rght_duty against its value at the previous lft_vld.
REQ-027 If both differences are <=TOL, the run counter SHALL increment, saturating at SETTLE_N; otherwise it SHALL clear to 0.
REQ-028 settled SHALL equal (run==SETTLE_N); any stuck bit set SHALL force the run counter to 0.
REQ-029 The first lft_vld after reset SHALL only seed the history and SHALL NOT count as a stable period.

Reset
REQ-030 rst SHALL force both FSMs to WAIT_EDGE, clear all counters and edge-history registers, and set duties=0, vld=0, stuck=0, ovr_lap=0, settled=0.
REQ-031 rst asserted mid-period SHALL discard the partial measurement; the first edge after reset SHALL produce no vld.

Structure
REQ-032 Package pwm_mon_pkg SHALL hold the channel state enum, the constants MID=1024 and HI_MAX=2047, and the counter and duty width constants.
REQ-033 The per-motor FSM, counters and stuck logic SHALL be sub-module pwm_chan_meas, instantiated twice.
REQ-034 The overlap and settled logic SHALL reside in the top module.

Verification
REQ-035 Period 2048 with PWM1 high 1024 on both sides -> vld every 2048 clocks, duty=0, settled=1 after the 9th lft_vld.
REQ-036 PWM1 high 1536 on lft and 512 on rght, period 2048 -> lft_duty=+512, rght_duty=-512.
REQ-037 PWM1_lft held high 5000 clocks -> stuck[1]=1 and lft_duty=+1023 at 4096 clocks after the last edge; after resuming -> stuck clears at the edge, next lft_vld one full period later.
REQ-038 One cycle of PWM1_rght=PWM2_rght=1 -> ovr_lap=1 the next cycle, held until clr_err.
REQ-039 With settled=1, lft high time stepped from 1024 to 1100 -> settled=0 at that lft_vld, re-asserts after 8 stable periods.
REQ-040 rst pulsed mid-period -> all outputs 0, no vld on the first subsequent edge.
